palette_write_arbiter: RTL and testbench

Single-clock controller that owns the write port of the colour palette RAM and shares it among three sources: host single-entry writes, a streamed burst loader for contiguous ranges, and an internal clear sequencer that zeroes the whole table. Sits between the host register interface or DMA and the palette's write side. Its clock is the palette write clock. It issues at most one palette write per cycle.

---
 rtl/palette_pkg.sv | 24 ++
 rtl/palette_rr_arb.sv | 31 +++
 rtl/palette_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_palette_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and width helpers for the palette write arbiter.
package palette_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_HOST = 1'b0,
    GRANT_STRM = 1'b1
  } grant_t;

  function automatic int index_width(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

  // One extra bit so a burst can cover the whole table.
  function automatic int count_width(input int length);
    return index_width(length) + 1;
  endfunction

endpackage

// File: rtl/palette_rr_arb.sv
// Two-way round-robin arbiter between host writes and the burst stream.
// Grants are permissions; a beat happens when a grant meets its request.
module palette_rr_arb
  import palette_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_host,
  input  logic req_strm,
  input  logic enable,
  output logic gnt_host,
  output logic gnt_strm
);

  grant_t last_grant;

  assign gnt_host = enable && (!req_strm || last_grant == GRANT_STRM);
  assign gnt_strm = enable && (!req_host || last_grant == GRANT_HOST);

  // Starting from "stream last" lets the host win the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant <= GRANT_STRM;
    end else if (gnt_host && req_host) begin
      last_grant <= GRANT_HOST;
    end else if (gnt_strm && req_strm) begin
      last_grant <= GRANT_STRM;
    end
  end

endmodule

// File: rtl/palette_write_arbiter.sv
// Owns the palette RAM write port: host writes, streamed bursts and a full clear.
// Define PALETTE_WRITE_BLANK_GATE_EN to only advance writes while blank_i is high.
module palette_write_arbiter
  import palette_pkg::*;
#(
  parameter int PALETTE_LENGTH = 256,
  parameter int COLOR_BITS     = 12,
  localparam int IW            = index_width(PALETTE_LENGTH),
  localparam int CW            = count_width(PALETTE_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  blank_i,
  output logic                  busy_o,
  input  logic                  host_valid_i,
  output logic                  host_ready_o,
  input  logic [IW-1:0]         host_index_i,
  input  logic [COLOR_BITS-1:0] host_color_i,
  input  logic                  burst_start_i,
  input  logic [IW-1:0]         burst_base_i,
  input  logic [CW-1:0]         burst_count_i,
  input  logic                  strm_valid_i,
  output logic                  strm_ready_o,
  input  logic [COLOR_BITS-1:0] strm_color_i,
  output logic                  burst_done_o,
  output logic                  pal_wr_en_o,
  output logic [IW-1:0]         pal_wr_index_o,
  output logic [COLOR_BITS-1:0] pal_wr_color_o
);

  state_t        state;
  logic [IW-1:0] wr_ptr;
  logic [CW-1:0] remaining;
  logic [IW-1:0] clr_idx;
  logic          gate;
  logic          in_burst;
  logic          arb_enable;
  logic          gnt_host;
  logic          gnt_strm;
  logic          host_fire;
  logic          strm_fire;

`ifdef PALETTE_WRITE_BLANK_GATE_EN
  assign gate = blank_i;
`else
  logic unused_blank;
  assign unused_blank = blank_i;
  assign gate         = 1'b1;
`endif

  assign in_burst   = (state == BURST);
  assign arb_enable = !clear_i && gate && (state != CLEAR);

  palette_rr_arb u_arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .req_host (host_valid_i),
    .req_strm (strm_valid_i && in_burst),
    .enable   (arb_enable),
    .gnt_host (gnt_host),
    .gnt_strm (gnt_strm)
  );

  assign host_ready_o = gnt_host;
  assign strm_ready_o = gnt_strm && in_burst;
  assign host_fire    = host_valid_i && host_ready_o;
  assign strm_fire    = strm_valid_i && strm_ready_o;

  // Clear always wins; a clear during a burst drops it without a done pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      remaining      <= '0;
      clr_idx        <= '0;
      busy_o         <= 1'b0;
      burst_done_o   <= 1'b0;
      pal_wr_en_o    <= 1'b0;
      pal_wr_index_o <= '0;
      pal_wr_color_o <= '0;
    end else begin
      pal_wr_en_o  <= 1'b0;
      burst_done_o <= 1'b0;
      busy_o       <= (state != IDLE);

      if (host_fire) begin
        pal_wr_en_o    <= 1'b1;
        pal_wr_index_o <= host_index_i;
        pal_wr_color_o <= host_color_i;
      end

      case (state)
        IDLE: begin
          if (clear_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (burst_start_i) begin
            wr_ptr    <= burst_base_i;
            remaining <= burst_count_i;
            if (burst_count_i == '0) begin
              burst_done_o <= 1'b1;
            end else begin
              state <= BURST;
            end
          end
        end

        BURST: begin
          if (clear_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (strm_fire) begin
            pal_wr_en_o    <= 1'b1;
            pal_wr_index_o <= wr_ptr;
            pal_wr_color_o <= strm_color_i;
            wr_ptr         <= wr_ptr + IW'(1);
            remaining      <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              burst_done_o <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        CLEAR: begin
          if (gate) begin
            pal_wr_en_o    <= 1'b1;
            pal_wr_index_o <= clr_idx;
            pal_wr_color_o <= '0;
            clr_idx        <= clr_idx + IW'(1);
            if (clr_idx == {IW{1'b1}}) begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_write_arbiter.sv
// Scoreboard bench for palette_write_arbiter: a cycle model predicts readies,
// busy and every palette write, which the monitor pops as writes appear.
module tb_palette_write_arbiter;
  import palette_pkg::*;

  localparam int LEN = 256;
  localparam int IW  = 8;
  localparam int CB  = 12;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          blank_i = 1'b0;
  logic          busy_o;
  logic          host_valid_i = 1'b0;
  logic          host_ready_o;
  logic [IW-1:0] host_index_i = '0;
  logic [CB-1:0] host_color_i = '0;
  logic          burst_start_i = 1'b0;
  logic [IW-1:0] burst_base_i = '0;
  logic [IW:0]   burst_count_i = '0;
  logic          strm_valid_i = 1'b0;
  logic          strm_ready_o;
  logic [CB-1:0] strm_color_i = '0;
  logic          burst_done_o;
  logic          pal_wr_en_o;
  logic [IW-1:0] pal_wr_index_o;
  logic [CB-1:0] pal_wr_color_o;

  always #5 clk = ~clk;

  palette_write_arbiter #(
    .PALETTE_LENGTH (LEN),
    .COLOR_BITS     (CB)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .clear_i        (clear_i),
    .blank_i        (blank_i),
    .busy_o         (busy_o),
    .host_valid_i   (host_valid_i),
    .host_ready_o   (host_ready_o),
    .host_index_i   (host_index_i),
    .host_color_i   (host_color_i),
    .burst_start_i  (burst_start_i),
    .burst_base_i   (burst_base_i),
    .burst_count_i  (burst_count_i),
    .strm_valid_i   (strm_valid_i),
    .strm_ready_o   (strm_ready_o),
    .strm_color_i   (strm_color_i),
    .burst_done_o   (burst_done_o),
    .pal_wr_en_o    (pal_wr_en_o),
    .pal_wr_index_o (pal_wr_index_o),
    .pal_wr_color_o (pal_wr_color_o)
  );

  typedef struct packed {
    logic          wr;
    logic          done;
    logic [IW-1:0] idx;
    logic [CB-1:0] col;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            test_count = 0;
  int            fail_count = 0;
  state_t        m_state = IDLE;
  grant_t        m_last = GRANT_STRM;
  logic [IW-1:0] m_ptr = '0;
  logic [IW:0]   m_rem = '0;
  int            m_clr = 0;
  logic          m_busy = 1'b0;
  logic          blank_next = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, then check readies/busy and push the writes it should cause.
  task automatic applyStimulus(input logic hv, input logic [IW-1:0] hi, input logic [CB-1:0] hc,
                               input logic sv, input logic [CB-1:0] sc,
                               input logic st, input logic [IW-1:0] bb, input logic [IW:0] bc,
                               input logic clr);
    logic g, exp_h, exp_s;
    @(posedge clk);
    #1;
    reset_i       = 1'b0;
    blank_i       = blank_next;
    host_valid_i  = hv;
    host_index_i  = hi;
    host_color_i  = hc;
    strm_valid_i  = sv;
    strm_color_i  = sc;
    burst_start_i = st;
    burst_base_i  = bb;
    burst_count_i = bc;
    clear_i       = clr;
    @(negedge clk);
`ifdef PALETTE_WRITE_BLANK_GATE_EN
    g = blank_i;
`else
    g = 1'b1;
`endif
    exp_h = !clr && g && (m_state != CLEAR) && ((m_state != BURST) || !sv || (m_last == GRANT_STRM));
    exp_s = !clr && g && (m_state == BURST) && (!hv || (m_last == GRANT_HOST));
    checkOutput("host_ready", 32'(host_ready_o), 32'(exp_h));
    checkOutput("strm_ready", 32'(strm_ready_o), 32'(exp_s));
    checkOutput("busy", 32'(busy_o), 32'(m_busy));
    m_busy = (m_state != IDLE);
    if (hv && exp_h) begin
      sb.push_back({1'b1, 1'b0, hi, hc});
      m_last = GRANT_HOST;
    end else if (sv && exp_s) begin
      m_last = GRANT_STRM;
    end
    case (m_state)
      IDLE: begin
        if (clr) begin
          for (int i = 0; i < LEN; i++) sb.push_back({1'b1, 1'b0, IW'(i), {CB{1'b0}}});
          m_state = CLEAR;
          m_clr   = LEN;
        end else if (st) begin
          m_ptr = bb;
          m_rem = bc;
          if (bc == '0) sb.push_back({1'b0, 1'b1, {IW{1'b0}}, {CB{1'b0}}});
          else m_state = BURST;
        end
      end
      BURST: begin
        if (clr) begin
          for (int i = 0; i < LEN; i++) sb.push_back({1'b1, 1'b0, IW'(i), {CB{1'b0}}});
          m_state = CLEAR;
          m_clr   = LEN;
        end else if (sv && exp_s) begin
          sb.push_back({1'b1, (m_rem == 1), m_ptr, sc});
          m_ptr = m_ptr + 1'b1;
          m_rem = m_rem - 1'b1;
          if (m_rem == '0) m_state = IDLE;
        end
      end
      default: begin
        if (g) begin
          m_clr--;
          if (m_clr == 0) m_state = IDLE;
        end
      end
    endcase
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drainCheck(input string tag);
    idleCycle();
    idleCycle();
    #1;
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_i       = 1'b1;
    blank_i       = blank_next;
    host_valid_i  = 1'b0;
    strm_valid_i  = 1'b0;
    burst_start_i = 1'b0;
    clear_i       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(burst_done_o), 32'd0);
    checkOutput("rst_wr_en", 32'(pal_wr_en_o), 32'd0);
    checkOutput("rst_index", 32'(pal_wr_index_o), 32'd0);
    checkOutput("rst_color", 32'(pal_wr_color_o), 32'd0);
    sb.delete();
    m_state = IDLE;
    m_last  = GRANT_STRM;
    m_busy  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset_i && (pal_wr_en_o || burst_done_o)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'({pal_wr_en_o, burst_done_o}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("wr_en", 32'(pal_wr_en_o), 32'(mon_e.wr));
        checkOutput("burst_done", 32'(burst_done_o), 32'(mon_e.done));
        if (mon_e.wr) begin
          checkOutput("wr_index", 32'(pal_wr_index_o), 32'(mon_e.idx));
          checkOutput("wr_color", 32'(pal_wr_color_o), 32'(mon_e.col));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    // Single host write, then a few more at varied entries.
    applyStimulus(1'b1, 8'd5, 12'hABC, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    idleCycle();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, IW'($urandom_range(0, LEN - 1)), CB'($urandom), 1'b0, '0, 1'b0, '0, '0, 1'b0);
    drainCheck("host_drain");

    // Wrapping burst with a continuous stream.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd250, 9'd10, 1'b0);
    for (int i = 0; i < 40 && m_state == BURST; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 12'(12'h100 + i), 1'b0, '0, '0, 1'b0);
    drainCheck("wrap_drain");

    // Host and stream contending for every cycle of a 4-beat burst.
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd16, 9'd4, 1'b0);
    for (int i = 0; i < 40 && m_state == BURST; i++)
      applyStimulus(1'b1, 8'(8'h40 + i), 12'(12'hC00 + i), 1'b1, 12'(12'h200 + i), 1'b0, '0, '0, 1'b0);
    drainCheck("rr_drain");

    // Clear arriving after the third burst beat.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd100, 9'd8, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 12'(12'h300 + i), 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 8'h33, 12'h555, 1'b1, 12'h777, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 300 && m_state == CLEAR; i++)
      applyStimulus(1'b1, 8'h33, 12'h555, 1'b1, 12'h777, 1'b0, '0, '0, 1'b0);
    drainCheck("clear_drain");

    // Zero-length burst only pulses done.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd7, 9'd0, 1'b0);
    drainCheck("zero_drain");

    // Reset while a burst is still outstanding.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd200, 9'd6, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h4A1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h4A2, 1'b0, '0, '0, 1'b0);
    drainCheck("pre_reset_drain");
    doReset();
    drainCheck("post_reset_drain");

`ifdef PALETTE_WRITE_BLANK_GATE_EN
    // Outside blanking nothing advances; the burst resumes where it stalled.
    blank_next = 1'b0;
    applyStimulus(1'b1, 8'd9, 12'h999, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'd10, 9'd3, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 12'h510, 1'b0, '0, '0, 1'b0);
    blank_next = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h510, 1'b0, '0, '0, 1'b0);
    blank_next = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 12'h511, 1'b0, '0, '0, 1'b0);
    blank_next = 1'b1;
    for (int i = 0; i < 20 && m_state == BURST; i++)
      applyStimulus(1'b0, '0, '0, 1'b1, 12'(12'h511 + i), 1'b0, '0, '0, 1'b0);
    drainCheck("gate_drain");
`else
    // blank_i has no effect without gating.
    blank_next = 1'b0;
    applyStimulus(1'b1, 8'd7, 12'h0F0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    drainCheck("nogate_drain");
    blank_next = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
